game_state_ctrl: RTL and testbench
==================================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at reset and restart (1..3).
REQ-002 SHALL have parameter HIT_FRAMES, default 60, frame ticks spent in HIT (1..255).
REQ-003 SHALL have parameter INVULN_FRAMES, default 120, frame ticks of post-respawn invulnerability (1..255).
REQ-004 SHALL have port clk, input, 1, system clock (100 MHz); the block uses one clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, level, any movement button pressed.
REQ-007 SHALL have port death_signal, input, 1, level, OR of all enemy/bomberman overlaps.
REQ-008 SHALL have port game_over_in, input, 1, level, bomberman caught in explosion.
REQ-009 SHALL have port frame_tick, input, 1, single-cycle pulse, once per video frame.
REQ-010 SHALL have port lives, output, 2, remaining lives.
REQ-011 SHALL have port state, output, 3, encoding IDLE=0, PLAY=1, HIT=2, RESPAWN=3, GAMEOVER=4.
REQ-012 SHALL have port freeze, output, 1, high when movers must hold position.
REQ-013 SHALL have port respawn, output, 1, single-cycle pulse that returns bomberman to spawn.
REQ-014 SHALL have port invuln, output, 1, high while the invulnerability counter is nonzero.
REQ-015 SHALL have port hit_flash, output, 1, high in HIT; the pixel mux shows the damage colour.
REQ-016 SHALL have port game_over, output, 1, high in GAMEOVER.

Function
REQ-017 SHALL register all outputs; each output changes one cycle after the causing input is sampled.
REQ-018 SHALL implement an IDLE state: freeze=1; start=1 moves the FSM to PLAY.
REQ-019 SHALL implement a PLAY state: freeze=0.
REQ-020 SHALL, in PLAY, handle game_over_in=1 as follows: go to GAMEOVER and set lives to 0; this has priority over death_signal in the same cycle.
REQ-021 SHALL, in PLAY, handle death_signal=1 with invuln=0 as follows: decrement lives once; go to GAMEOVER if the result is 0, otherwise go to HIT.
REQ-022 SHALL ignore death_signal while invuln=1 or in any state other than PLAY; no further decrement occurs while the signal stays high.
REQ-023 SHALL implement a HIT state: freeze=1, hit_flash=1.
REQ-024 SHALL, in HIT, use an 8-bit frame counter cleared on entry that counts only frame_tick pulses arriving after the entry cycle.
REQ-025 SHALL, in HIT, go to RESPAWN when the frame counter reaches HIT_FRAMES.
REQ-026 SHALL implement a RESPAWN state that lasts exactly one cycle: respawn=1, freeze=1; it then goes to PLAY and loads the invulnerability counter with INVULN_FRAMES.
REQ-027 SHALL decrement the invulnerability counter on each frame_tick while in PLAY.
REQ-028 SHALL saturate the invulnerability counter at 0.
REQ-029 SHALL assert invuln whenever the invulnerability counter is nonzero.
REQ-030 SHALL implement a GAMEOVER state: freeze=1, game_over=1.
REQ-031 SHALL detect a rising edge of start (a registered copy of start that was 0 in the prior cycle) only after entering GAMEOVER.
REQ-032 SHALL, on that rising edge in GAMEOVER, go to IDLE, reload lives to LIVES_INIT, and clear the counters.
REQ-033 SHALL NOT restart from GAMEOVER while start is held high continuously from PLAY.
REQ-034 SHALL never wrap lives below 0 or above LIVES_INIT.
REQ-035 SHALL treat an unused state encoding as follows: go to IDLE on the next cycle.
REQ-036 SHALL, when frame_tick coincides with a state transition, count the tick only in the state being left (PLAY invuln decrement) or not at all (HIT entry).

Reset
REQ-037 SHALL, while reset=0, asynchronously force state=IDLE, lives=LIVES_INIT, counters=0, and all 1-bit outputs to 0 except freeze=1.
REQ-038 SHALL, when reset asserts mid-HIT or mid-invulnerability, abandon that operation with no respawn pulse.
REQ-039 SHALL, after reset deasserts, resume on the first clk edge with normal IDLE behaviour.

Verification
REQ-040 SHALL cover: reset, then start=1 -> state=1, lives=3, freeze=0 one cycle later.
REQ-041 SHALL cover: in PLAY, death_signal held high for 500 cycles -> lives=2, state=2, hit_flash=1; after 60 frame_ticks state=3 for one cycle with respawn=1, then state=1, invuln=1.
REQ-042 SHALL cover: death_signal pulsed during the 120-tick invulnerability window -> lives unchanged; after the 120th tick invuln=0 and the next death_signal gives lives=1.
REQ-043 SHALL cover: lives=1 and death_signal=1 -> lives=0, state=4, game_over=1; start held high -> stays in 4; start released then pressed -> state=0, lives=3.
REQ-044 SHALL cover: death_signal and game_over_in high in the same PLAY cycle -> state=4, lives=0, hit_flash never asserted.
REQ-045 SHALL cover: reset pulled low mid-HIT (frame counter 30) -> immediate state=0, lives=3, respawn stays 0.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game flow controller: lives, hit/respawn sequencing, post-respawn
// invulnerability and game-over/restart handling for the bomberman core.
// The FSM state is exported on the `state` port so checkers can bind to it.
// All outputs are registered from next-state values, so each output moves
// on the same clock edge as the state register.
module game_state_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int HIT_FRAMES    = 60,
  parameter int INVULN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,         // asynchronous, active low
  input  logic       start,
  input  logic       death_signal,
  input  logic       game_over_in,
  input  logic       frame_tick,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       freeze,
  output logic       respawn,
  output logic       invuln,
  output logic       hit_flash,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_HIT      = 3'd2,
    S_RESPAWN  = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_LIM = 2'(LIVES_INIT);
  localparam logic [7:0] HIT_LIM   = 8'(HIT_FRAMES);
  localparam logic [7:0] INV_LIM   = 8'(INVULN_FRAMES);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic       start_q;
  logic       freeze_q, respawn_q, invuln_q, hit_flash_q, game_over_q;

  // Next-state logic for the FSM, lives and both frame counters.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    hit_cnt_d = hit_cnt_q;
    inv_cnt_d = inv_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PLAY;
      end
      S_PLAY: begin
        // A tick in the cycle we leave PLAY still counts against invuln.
        if (frame_tick && (inv_cnt_q != 8'd0)) inv_cnt_d = inv_cnt_q - 8'd1;
        if (game_over_in) begin
          // Explosion outranks an enemy overlap in the same cycle.
          state_d   = S_GAMEOVER;
          lives_d   = 2'd0;
          inv_cnt_d = 8'd0;
        end else if (death_signal && (inv_cnt_q == 8'd0)) begin
          if (lives_q <= 2'd1) begin
            state_d   = S_GAMEOVER;
            lives_d   = 2'd0;
            inv_cnt_d = 8'd0;
          end else begin
            state_d   = S_HIT;
            lives_d   = lives_q - 2'd1;
            hit_cnt_d = 8'd0;
          end
        end
      end
      S_HIT: begin
        // The entry cycle belongs to PLAY, so only later ticks land here.
        if (frame_tick) begin
          hit_cnt_d = hit_cnt_q + 8'd1;
          if (hit_cnt_d == HIT_LIM) state_d = S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        state_d   = S_PLAY;
        hit_cnt_d = 8'd0;
        inv_cnt_d = INV_LIM;
      end
      S_GAMEOVER: begin
        // start_q blocks a restart while the button is held from PLAY.
        if (start && !start_q) begin
          state_d   = S_IDLE;
          lives_d   = LIVES_LIM;
          hit_cnt_d = 8'd0;
          inv_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        lives_d   = LIVES_LIM;
        hit_cnt_d = 8'd0;
        inv_cnt_d = 8'd0;
      end
    endcase
  end

  // State, lives, counters and start history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lives_q   <= LIVES_LIM;
      hit_cnt_q <= 8'd0;
      inv_cnt_q <= 8'd0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      hit_cnt_q <= hit_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      start_q   <= start;
    end
  end

  // Output registers decoded from the next state so they track state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freeze_q    <= 1'b1;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      hit_flash_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      freeze_q    <= (state_d != S_PLAY);
      respawn_q   <= (state_d == S_RESPAWN);
      invuln_q    <= (inv_cnt_d != 8'd0);
      hit_flash_q <= (state_d == S_HIT);
      game_over_q <= (state_d == S_GAMEOVER);
    end
  end

  assign lives     = lives_q;
  assign state     = state_q;
  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign invuln    = invuln_q;
  assign hit_flash = hit_flash_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters
// (3 lives, 60 hit frames, 120 invulnerability frames).
module tb_game_state_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       death_signal;
  logic       game_over_in;
  logic       frame_tick;
  logic [1:0] lives;
  logic [2:0] state;
  logic       freeze;
  logic       respawn;
  logic       invuln;
  logic       hit_flash;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  game_state_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .death_signal (death_signal),
    .game_over_in (game_over_in),
    .frame_tick   (frame_tick),
    .lives        (lives),
    .state        (state),
    .freeze       (freeze),
    .respawn      (respawn),
    .invuln       (invuln),
    .hit_flash    (hit_flash),
    .game_over    (game_over)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_tick n times, one idle cycle between pulses.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    death_signal = 1'b0;
    game_over_in = 1'b0;
    frame_tick   = 1'b0;

    // Reset values.
    repeat (3) step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_freeze", 8'(freeze), 8'd1);
    chk("rst_respawn", 8'(respawn), 8'd0);
    chk("rst_invuln", 8'(invuln), 8'd0);
    chk("rst_hit_flash", 8'(hit_flash), 8'd0);
    chk("rst_game_over", 8'(game_over), 8'd0);

    // Release reset: stays IDLE without start.
    reset = 1'b1;
    step();
    chk("idle_state", 8'(state), 8'd0);
    chk("idle_freeze", 8'(freeze), 8'd1);

    // start -> PLAY one cycle later.
    start = 1'b1;
    step();
    chk("play_state", 8'(state), 8'd1);
    chk("play_lives", 8'(lives), 8'd3);
    chk("play_freeze", 8'(freeze), 8'd0);
    start = 1'b0;

    // death held high: single decrement, HIT.
    death_signal = 1'b1;
    step();
    chk("hit1_state", 8'(state), 8'd2);
    chk("hit1_lives", 8'(lives), 8'd2);
    chk("hit1_flash", 8'(hit_flash), 8'd1);
    chk("hit1_freeze", 8'(freeze), 8'd1);
    do_ticks(59);
    chk("hit1_59_state", 8'(state), 8'd2);
    chk("hit1_59_lives", 8'(lives), 8'd2);
    frame_tick = 1'b1;
    step();
    chk("resp1_state", 8'(state), 8'd3);
    chk("resp1_pulse", 8'(respawn), 8'd1);
    chk("resp1_freeze", 8'(freeze), 8'd1);
    frame_tick = 1'b0;
    step();
    chk("resp1_play_state", 8'(state), 8'd1);
    chk("resp1_play_invuln", 8'(invuln), 8'd1);
    chk("resp1_pulse_end", 8'(respawn), 8'd0);
    // Rest of the 500-cycle hold: invulnerable, no further decrement.
    repeat (379) step();
    chk("hold_lives", 8'(lives), 8'd2);
    chk("hold_state", 8'(state), 8'd1);
    death_signal = 1'b0;

    // Death pulses during the invulnerability window are ignored.
    death_signal = 1'b1;
    step();
    death_signal = 1'b0;
    chk("inv_pulse_lives", 8'(lives), 8'd2);
    chk("inv_pulse_state", 8'(state), 8'd1);
    do_ticks(119);
    chk("inv_119_invuln", 8'(invuln), 8'd1);
    death_signal = 1'b1;
    step();
    death_signal = 1'b0;
    chk("inv_119_lives", 8'(lives), 8'd2);
    frame_tick = 1'b1;
    step();
    chk("inv_120_invuln", 8'(invuln), 8'd0);
    chk("inv_120_state", 8'(state), 8'd1);

    // Death coinciding with a tick: tick is not counted in HIT.
    death_signal = 1'b1;
    frame_tick   = 1'b1;
    step();
    death_signal = 1'b0;
    frame_tick   = 1'b0;
    chk("hit2_state", 8'(state), 8'd2);
    chk("hit2_lives", 8'(lives), 8'd1);
    do_ticks(59);
    chk("hit2_59_state", 8'(state), 8'd2);
    do_ticks(1);
    chk("hit2_back_state", 8'(state), 8'd1);
    chk("hit2_back_invuln", 8'(invuln), 8'd1);
    do_ticks(120);
    chk("hit2_inv_done", 8'(invuln), 8'd0);

    // Last life lost with start held; no restart until start re-pressed.
    start        = 1'b1;
    death_signal = 1'b1;
    step();
    death_signal = 1'b0;
    chk("go_state", 8'(state), 8'd4);
    chk("go_lives", 8'(lives), 8'd0);
    chk("go_flag", 8'(game_over), 8'd1);
    chk("go_freeze", 8'(freeze), 8'd1);
    chk("go_hit_flash", 8'(hit_flash), 8'd0);
    repeat (5) step();
    chk("go_held_state", 8'(state), 8'd4);
    start = 1'b0;
    step();
    chk("go_release_state", 8'(state), 8'd4);
    start = 1'b1;
    step();
    chk("restart_state", 8'(state), 8'd0);
    chk("restart_lives", 8'(lives), 8'd3);
    chk("restart_game_over", 8'(game_over), 8'd0);
    chk("restart_freeze", 8'(freeze), 8'd1);
    step();
    chk("restart_play", 8'(state), 8'd1);
    start = 1'b0;

    // Explosion and overlap in the same cycle: straight to GAMEOVER.
    death_signal = 1'b1;
    game_over_in = 1'b1;
    step();
    death_signal = 1'b0;
    game_over_in = 1'b0;
    chk("both_state", 8'(state), 8'd4);
    chk("both_lives", 8'(lives), 8'd0);
    chk("both_hit_flash", 8'(hit_flash), 8'd0);
    step();
    chk("both_hit_flash2", 8'(hit_flash), 8'd0);
    start = 1'b1;
    step();
    chk("both_restart", 8'(state), 8'd0);
    step();
    start = 1'b0;
    chk("both_play", 8'(state), 8'd1);
    chk("both_play_lives", 8'(lives), 8'd3);

    // Reset asserted mid-HIT at frame count 30.
    death_signal = 1'b1;
    step();
    death_signal = 1'b0;
    chk("hit3_state", 8'(state), 8'd2);
    do_ticks(30);
    reset = 1'b0;
    #1;
    chk("async_state", 8'(state), 8'd0);
    chk("async_lives", 8'(lives), 8'd3);
    chk("async_respawn", 8'(respawn), 8'd0);
    chk("async_freeze", 8'(freeze), 8'd1);
    chk("async_hit_flash", 8'(hit_flash), 8'd0);
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step();
      chk("async_hold_respawn", 8'(respawn), 8'd0);
    end
    frame_tick = 1'b0;
    reset = 1'b1;
    step();
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_lives", 8'(lives), 8'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_play", 8'(state), 8'd1);
    chk("post_rst_invuln", 8'(invuln), 8'd0);
    chk("post_rst_respawn", 8'(respawn), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
